// File: rtl/branch_redirect_pkg.sv
// Shared processor package: branch-unit types and constants used by the
// execute-stage branch resolution logic.
//   FUNCT3_*   : branch condition encodings (consumed by the logical unit)
//   INSN_BYTES : instruction size, used for link value and alignment
//   br_kind_t  : op kind presented to the redirect stage
//   br_state_t : redirect stage FSM states
package branch_redirect_pkg;

   localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
   localparam logic [2:0] FUNCT3_BNE  = 3'b001;
   localparam logic [2:0] FUNCT3_BLT  = 3'b100;
   localparam logic [2:0] FUNCT3_BGE  = 3'b101;
   localparam logic [2:0] FUNCT3_BLTU = 3'b110;
   localparam logic [2:0] FUNCT3_BGEU = 3'b111;

   localparam int unsigned INSN_BYTES = 4;

   // Encoding 3 is reserved and behaves as BR_COND.
   typedef enum logic [1:0] {
      BR_COND = 2'd0,
      BR_JAL  = 2'd1,
      BR_JALR = 2'd2
   } br_kind_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REDIRECT = 2'd1,
      FLUSH    = 2'd2
   } br_state_t;

endpackage

// File: rtl/branch_redirect_if.sv
// Redirect channel from the branch stage to fetch.
//   redir_valid : redirect request (master -> slave)
//   redir_ready : fetch accepts the redirect (slave -> master)
//   redir_pc    : redirect target, stable while redir_valid is high
interface branch_redirect_if;

   logic        redir_valid;
   logic        redir_ready;
   logic [31:0] redir_pc;

   modport master (
      output redir_valid,
      output redir_pc,
      input  redir_ready
   );

   modport slave (
      input  redir_valid,
      input  redir_pc,
      output redir_ready
   );

endinterface

// File: rtl/branch_target.sv
// Combinational control-transfer target / link computation.
//   kind_i       : op kind (3 treated as BR_COND)
//   pc_i, imm_i  : op PC and sign-extended offset
//   rs1_i        : JALR base register
//   target_o     : transfer target (JALR has bit 0 cleared)
//   link_o       : pc_i + INSN_BYTES
//   misaligned_o : target not aligned to an instruction boundary
//   is_jump_o    : op is an unconditional JAL/JALR
module branch_target
   import branch_redirect_pkg::*;
(
   input  logic [1:0]  kind_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] imm_i,
   input  logic [31:0] rs1_i,
   output logic [31:0] target_o,
   output logic [31:0] link_o,
   output logic        misaligned_o,
   output logic        is_jump_o
);

   logic is_jalr;

   always_comb begin
      is_jalr   = (kind_i == BR_JALR);
      is_jump_o = is_jalr || (kind_i == BR_JAL);
      if (is_jalr) begin
         target_o = (rs1_i + imm_i) & ~32'd1;
      end else begin
         target_o = pc_i + imm_i;
      end
      link_o       = pc_i + 32'(INSN_BYTES);
      misaligned_o = |target_o[1:0];
   end

endmodule

// File: rtl/branch_redirect.sv
// Execute-stage branch/jump resolution. Accepts one op at a time, issues a
// PC redirect to fetch for taken aligned transfers, writes the link value for
// JAL/JALR, then holds flush for FLUSH_CYCLES cycles after the handshake.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   valid_i/ready_o  : upstream op handshake (ready only in IDLE)
//   kind_i           : op kind
//   branch_taken_i   : condition result, BR_COND only
//   pc_i/imm_i/rs1_i : operands
//   redir            : redirect channel to fetch (master)
//   flush_o          : kill younger instructions
//   link_valid_o     : one-cycle link write pulse, value on link_o
//   misalign_o       : one-cycle misaligned-target pulse
//   redir_cnt_o      : saturating count of completed redirects
module branch_redirect
   import branch_redirect_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned CNT_W        = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               valid_i,
   output logic               ready_o,
   input  logic [1:0]         kind_i,
   input  logic               branch_taken_i,
   input  logic [31:0]        pc_i,
   input  logic [31:0]        imm_i,
   input  logic [31:0]        rs1_i,
   branch_redirect_if.master  redir,
   output logic               flush_o,
   output logic               link_valid_o,
   output logic [31:0]        link_o,
   output logic               misalign_o,
   output logic [CNT_W-1:0]   redir_cnt_o
);

   // Counter only needs to hold FLUSH_CYCLES-1.
   localparam int unsigned FcW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   br_state_t        state_q, state_d;
   logic [FcW-1:0]   flush_cnt_q, flush_cnt_d;
   logic [31:0]      target_q, target_d;
   logic [31:0]      link_q, link_d;
   logic             link_valid_q, link_valid_d;
   logic             misalign_q, misalign_d;
   logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;

   logic [31:0] target;
   logic [31:0] link;
   logic        misaligned;
   logic        is_jump;

   branch_target u_target (
      .kind_i       (kind_i),
      .pc_i         (pc_i),
      .imm_i        (imm_i),
      .rs1_i        (rs1_i),
      .target_o     (target),
      .link_o       (link),
      .misaligned_o (misaligned),
      .is_jump_o    (is_jump)
   );

   always_comb begin
      state_d           = state_q;
      flush_cnt_d       = flush_cnt_q;
      target_d          = target_q;
      link_d            = link_q;
      link_valid_d      = 1'b0;
      misalign_d        = 1'b0;
      redir_cnt_d       = redir_cnt_q;
      ready_o           = 1'b0;
      flush_o           = 1'b0;
      redir.redir_valid = 1'b0;

      unique case (state_q)
         IDLE: begin
            ready_o = 1'b1;
            if (valid_i && (is_jump || branch_taken_i)) begin
               if (misaligned) begin
                  misalign_d = 1'b1;
               end else begin
                  state_d  = REDIRECT;
                  target_d = target;
                  if (is_jump) begin
                     link_valid_d = 1'b1;
                     link_d       = link;
                  end
               end
            end
         end
         REDIRECT: begin
            redir.redir_valid = 1'b1;
            flush_o           = 1'b1;
            if (redir.redir_ready) begin
               if (redir_cnt_q != '1) begin
                  redir_cnt_d = redir_cnt_q + 1'b1;
               end
               if (FLUSH_CYCLES > 0) begin
                  state_d     = FLUSH;
                  flush_cnt_d = FcW'(FLUSH_CYCLES - 1);
               end else begin
                  state_d = IDLE;
               end
            end
         end
         FLUSH: begin
            flush_o = 1'b1;
            if (flush_cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               flush_cnt_d = flush_cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         flush_cnt_q  <= '0;
         target_q     <= '0;
         link_q       <= '0;
         link_valid_q <= 1'b0;
         misalign_q   <= 1'b0;
         redir_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         flush_cnt_q  <= flush_cnt_d;
         target_q     <= target_d;
         link_q       <= link_d;
         link_valid_q <= link_valid_d;
         misalign_q   <= misalign_d;
         redir_cnt_q  <= redir_cnt_d;
      end
   end

   assign redir.redir_pc = target_q;
   assign link_valid_o   = link_valid_q;
   assign link_o         = link_q;
   assign misalign_o     = misalign_q;
   assign redir_cnt_o    = redir_cnt_q;

endmodule

// File: tb/tb_branch_redirect.sv
// Bench for branch_redirect: instance A (FLUSH_CYCLES=2, CNT_W=16) runs a
// vector table plus reset/busy sequences; instance B (FLUSH_CYCLES=0,
// CNT_W=2) checks zero-flush behaviour and counter saturation.
module tb_branch_redirect;
   import branch_redirect_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        valid_a, valid_b;
   logic [1:0]  kind;
   logic        taken;
   logic [31:0] pc, imm, rs1;

   logic        ready_a, flush_a, link_valid_a, misalign_a;
   logic [31:0] link_a;
   logic [15:0] cnt_a;
   logic        ready_b, flush_b, link_valid_b, misalign_b;
   logic [31:0] link_b;
   logic [1:0]  cnt_b;

   branch_redirect_if rif_a ();
   branch_redirect_if rif_b ();

   branch_redirect #(.FLUSH_CYCLES(2), .CNT_W(16)) dut_a (
      .clk_i (clk), .rst_i (rst), .valid_i (valid_a), .ready_o (ready_a),
      .kind_i (kind), .branch_taken_i (taken), .pc_i (pc), .imm_i (imm), .rs1_i (rs1),
      .redir (rif_a), .flush_o (flush_a), .link_valid_o (link_valid_a), .link_o (link_a),
      .misalign_o (misalign_a), .redir_cnt_o (cnt_a)
   );

   branch_redirect #(.FLUSH_CYCLES(0), .CNT_W(2)) dut_b (
      .clk_i (clk), .rst_i (rst), .valid_i (valid_b), .ready_o (ready_b),
      .kind_i (kind), .branch_taken_i (taken), .pc_i (pc), .imm_i (imm), .rs1_i (rs1),
      .redir (rif_b), .flush_o (flush_b), .link_valid_o (link_valid_b), .link_o (link_b),
      .misalign_o (misalign_b), .redir_cnt_o (cnt_b)
   );

   typedef struct {
      logic [1:0]  kind;
      logic        taken;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [31:0] rs1;
      int unsigned delay;
      logic        exp_redir;
      logic [31:0] exp_pc;
      logic        exp_lv;
      logic [31:0] exp_link;
      logic        exp_mis;
   } vec_t;

   vec_t        vecs[10];
   vec_t        sb[$];
   int          n_chk  = 0;
   int          n_fail = 0;
   int unsigned exp_cnt_a = 0;

   task automatic chk1(input string name, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [1:0] k, input logic t, input logic [31:0] p,
                               input logic [31:0] i, input logic [31:0] r,
                               input int unsigned d, input logic er, input logic [31:0] ep,
                               input logic elv, input logic [31:0] el, input logic em);
      vec_t v;
      v.kind = k; v.taken = t; v.pc = p; v.imm = i; v.rs1 = r; v.delay = d;
      v.exp_redir = er; v.exp_pc = ep; v.exp_lv = elv; v.exp_link = el; v.exp_mis = em;
      return v;
   endfunction

   task automatic drive(input logic [1:0] k, input logic t, input logic [31:0] p,
                        input logic [31:0] i, input logic [31:0] r);
      kind = k; taken = t; pc = p; imm = i; rs1 = r;
   endtask

   // Called at a negedge with instance A idle; returns at a negedge, idle again.
   task automatic run_a(input vec_t v);
      vec_t e;
      chk1("a_ready_idle", ready_a, 1'b1);
      drive(v.kind, v.taken, v.pc, v.imm, v.rs1);
      valid_a = 1'b1;
      sb.push_back(v);
      @(negedge clk);
      valid_a = 1'b0;
      e = sb.pop_front();
      chk1("a_misalign", misalign_a, e.exp_mis);
      chk1("a_link_valid", link_valid_a, e.exp_lv);
      if (e.exp_lv) chk32("a_link", link_a, e.exp_link);
      chk1("a_redir_valid", rif_a.redir_valid, e.exp_redir);
      chk1("a_flush", flush_a, e.exp_redir);
      chk1("a_ready_after", ready_a, !e.exp_redir);
      if (!e.exp_redir) begin
         chk32("a_cnt_hold", 32'(cnt_a), 32'(exp_cnt_a));
      end else begin
         chk32("a_redir_pc", rif_a.redir_pc, e.exp_pc);
         rif_a.redir_ready = (e.delay == 0);
         for (int i = 0; i < int'(e.delay); i++) begin
            @(negedge clk);
            chk1("a_wait_valid", rif_a.redir_valid, 1'b1);
            chk1("a_wait_ready", ready_a, 1'b0);
            chk1("a_wait_lv", link_valid_a, 1'b0);
            chk32("a_wait_pc", rif_a.redir_pc, e.exp_pc);
            if (i == int'(e.delay) - 1) rif_a.redir_ready = 1'b1;
         end
         @(negedge clk);
         // Leave ready high while idle: it must be ignored.
         exp_cnt_a++;
         for (int i = 0; i < 2; i++) begin
            chk1("a_fl_flush", flush_a, 1'b1);
            chk1("a_fl_valid", rif_a.redir_valid, 1'b0);
            chk1("a_fl_ready", ready_a, 1'b0);
            chk1("a_fl_lv", link_valid_a, 1'b0);
            @(negedge clk);
         end
         chk1("a_done_flush", flush_a, 1'b0);
         chk1("a_done_ready", ready_a, 1'b1);
         chk32("a_cnt", 32'(cnt_a), 32'(exp_cnt_a));
      end
   endtask

   task automatic run_b(input int unsigned delay, input logic [1:0] exp_cnt);
      drive(BR_COND, 1'b1, 32'h1000, 32'h40, 32'h0);
      valid_b = 1'b1;
      @(negedge clk);
      valid_b = 1'b0;
      chk1("b_redir_valid", rif_b.redir_valid, 1'b1);
      chk1("b_flush", flush_b, 1'b1);
      chk1("b_ready_busy", ready_b, 1'b0);
      chk32("b_redir_pc", rif_b.redir_pc, 32'h1040);
      rif_b.redir_ready = (delay == 0);
      for (int i = 0; i < int'(delay); i++) begin
         @(negedge clk);
         chk1("b_wait_valid", rif_b.redir_valid, 1'b1);
         chk1("b_wait_flush", flush_b, 1'b1);
         if (i == int'(delay) - 1) rif_b.redir_ready = 1'b1;
      end
      @(negedge clk);
      rif_b.redir_ready = 1'b0;
      chk1("b_done_flush", flush_b, 1'b0);
      chk1("b_done_valid", rif_b.redir_valid, 1'b0);
      chk1("b_done_ready", ready_b, 1'b1);
      chk32("b_cnt", 32'(cnt_b), 32'(exp_cnt));
   endtask

   initial begin
      vecs[0] = mk(BR_COND, 0, 32'h100, 32'h20, 0, 0, 0, 0, 0, 0, 0);
      vecs[1] = mk(BR_COND, 0, 32'h200, 32'h8, 0, 0, 0, 0, 0, 0, 0);
      vecs[2] = mk(BR_COND, 1, 32'h100, 32'hFFFF_FFF0, 0, 3, 1, 32'hF0, 0, 0, 0);
      vecs[3] = mk(BR_JALR, 0, 32'h40, 32'h0, 32'h2003, 0, 0, 0, 0, 0, 1);
      vecs[4] = mk(BR_JAL, 0, 32'hFFFF_FFFC, 32'h8, 0, 0, 1, 32'h4, 1, 32'h0, 0);
      vecs[5] = mk(2'd3, 1, 32'h1000, 32'h10, 32'hDEAD, 1, 1, 32'h1010, 0, 0, 0);
      vecs[6] = mk(2'd3, 0, 32'h1000, 32'h10, 0, 0, 0, 0, 0, 0, 0);
      vecs[7] = mk(BR_JAL, 0, 32'h10, 32'h6, 0, 0, 0, 0, 0, 0, 1);
      vecs[8] = mk(BR_JALR, 0, 32'h80, 32'h100, 32'h3001, 2, 1, 32'h3100, 1, 32'h84, 0);
      vecs[9] = mk(BR_COND, 1, 32'h0, 32'h2, 0, 0, 0, 0, 0, 0, 1);

      rst = 1'b1; valid_a = 1'b0; valid_b = 1'b0;
      rif_a.redir_ready = 1'b0; rif_b.redir_ready = 1'b0;
      drive(BR_COND, 1'b0, 0, 0, 0);
      repeat (2) @(negedge clk);
      chk1("rst_ready", ready_a, 1'b1);
      chk1("rst_flush", flush_a, 1'b0);
      chk1("rst_valid", rif_a.redir_valid, 1'b0);
      chk1("rst_lv", link_valid_a, 1'b0);
      chk1("rst_mis", misalign_a, 1'b0);
      chk32("rst_cnt", 32'(cnt_a), 32'h0);
      chk32("rst_pc", rif_a.redir_pc, 32'h0);
      chk32("rst_link", link_a, 32'h0);
      chk1("rst_ready_b", ready_b, 1'b1);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 10; i++) run_a(vecs[i]);
      @(negedge clk);
      chk1("tail_mis", misalign_a, 1'b0);
      chk1("tail_lv", link_valid_a, 1'b0);

      // Op presented while busy must be ignored.
      rif_a.redir_ready = 1'b0;
      drive(BR_COND, 1'b1, 32'h500, 32'h10, 0);
      valid_a = 1'b1;
      @(negedge clk);
      drive(BR_JALR, 1'b0, 32'h0, 32'h0, 32'h3);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk32("busy_pc", rif_a.redir_pc, 32'h510);
         chk1("busy_mis", misalign_a, 1'b0);
         chk1("busy_ready", ready_a, 1'b0);
      end
      valid_a = 1'b0;
      rif_a.redir_ready = 1'b1;
      exp_cnt_a++;
      repeat (3) begin
         @(negedge clk);
         chk1("busy_mis2", misalign_a, 1'b0);
      end
      chk1("busy_idle", ready_a, 1'b1);
      chk32("busy_cnt", 32'(cnt_a), 32'(exp_cnt_a));

      // Reset in FLUSH abandons the operation.
      drive(BR_JAL, 1'b0, 32'h200, 32'h100, 0);
      valid_a = 1'b1;
      @(negedge clk);
      valid_a = 1'b0;
      chk1("rf_lv", link_valid_a, 1'b1);
      chk32("rf_link", link_a, 32'h204);
      @(negedge clk);
      chk1("rf_in_flush", flush_a, 1'b1);
      chk1("rf_in_flush_v", rif_a.redir_valid, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_cnt_a = 0;
      chk1("rf_flush", flush_a, 1'b0);
      chk1("rf_ready", ready_a, 1'b1);
      chk32("rf_cnt", 32'(cnt_a), 32'(exp_cnt_a));
      chk32("rf_link0", link_a, 32'h0);
      for (int i = 0; i < 3; i++) begin
         chk1("rf_q_flush", flush_a, 1'b0);
         chk1("rf_q_valid", rif_a.redir_valid, 1'b0);
         chk1("rf_q_lv", link_valid_a, 1'b0);
         chk1("rf_q_mis", misalign_a, 1'b0);
         @(negedge clk);
      end

      // Zero flush cycles and 2-bit saturation.
      rif_a.redir_ready = 1'b0;
      run_b(0, 2'd1);
      run_b(1, 2'd2);
      run_b(0, 2'd3);
      run_b(2, 2'd3);
      run_b(0, 2'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
